// File: rtl/npc_pkg.sv
// Shared definitions for the NPC writeback path: widths, load funct3 codes
// and the writeback FSM state type.
package npc_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wbu_state_e;

endpackage

// File: rtl/npc_load_ext.sv
// Load data formatter: picks the addressed byte lane out of an aligned word
// and sign- or zero-extends it according to the load funct3.
module npc_load_ext
  import npc_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    addr_lo,
  input  logic [2:0]    funct3,
  output logic [DW-1:0] ext_data
);

  logic [DW-1:0] shifted_s;

  // Lane shift then width/sign selection; lanes past the word top read as 0.
  always_comb begin
    shifted_s = rdata >> {addr_lo, 3'b000};
    ext_data  = shifted_s;
    case (funct3)
      LB:      ext_data = {{(DW-8){shifted_s[7]}}, shifted_s[7:0]};
      LBU:     ext_data = {{(DW-8){1'b0}}, shifted_s[7:0]};
      LH:      ext_data = {{(DW-16){shifted_s[15]}}, shifted_s[15:0]};
      LHU:     ext_data = {{(DW-16){1'b0}}, shifted_s[15:0]};
      default: ext_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/npc_wbu.sv
// NPC writeback unit: retires ALU results immediately and loads after the
// memory response, driving the register file write port and a commit pulse.
module npc_wbu
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = npc_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = npc_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic [31:0]           in_pc,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid,
  output logic [31:0]           commit_pc
);

  wbu_state_e            state_r, state_nxt_s;
  logic                  capture_s;

  logic [ADDR_WIDTH-1:0] ld_rd_r;
  logic                  ld_wen_r;
  logic [2:0]            ld_funct3_r;
  logic [1:0]            ld_addr_lo_r;
  logic [31:0]           ld_pc_r;

  logic                  rf_wen_r, rf_wen_nxt_s;
  logic [ADDR_WIDTH-1:0] rf_waddr_r, rf_waddr_nxt_s;
  logic [DATA_WIDTH-1:0] rf_wdata_r, rf_wdata_nxt_s;
  logic                  commit_valid_r, commit_valid_nxt_s;
  logic [31:0]           commit_pc_r, commit_pc_nxt_s;
  logic [DATA_WIDTH-1:0] ld_data_s;

  npc_load_ext #(.DW(DATA_WIDTH)) u_load_ext (
    .rdata    (mem_rdata),
    .addr_lo  (ld_addr_lo_r),
    .funct3   (ld_funct3_r),
    .ext_data (ld_data_s)
  );

  assign in_ready     = (state_r == IDLE);
  assign mem_rready   = (state_r == WAIT_MEM);
  assign rf_wen       = rf_wen_r;
  assign rf_waddr     = rf_waddr_r;
  assign rf_wdata     = rf_wdata_r;
  assign commit_valid = commit_valid_r;
  assign commit_pc    = commit_pc_r;

  // Next state and next writeback/commit values; address/data hold unless written.
  always_comb begin
    state_nxt_s        = state_r;
    capture_s          = 1'b0;
    rf_wen_nxt_s       = 1'b0;
    rf_waddr_nxt_s     = rf_waddr_r;
    rf_wdata_nxt_s     = rf_wdata_r;
    commit_valid_nxt_s = 1'b0;
    commit_pc_nxt_s    = commit_pc_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_is_load) begin
          capture_s   = 1'b1;
          state_nxt_s = WAIT_MEM;
        end else if (in_valid) begin
          commit_valid_nxt_s = 1'b1;
          commit_pc_nxt_s    = in_pc;
          if (in_wen && (in_rd != {ADDR_WIDTH{1'b0}})) begin
            rf_wen_nxt_s   = 1'b1;
            rf_waddr_nxt_s = in_rd;
            rf_wdata_nxt_s = in_result;
          end else begin
            rf_wen_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_nxt_s        = IDLE;
          commit_valid_nxt_s = 1'b1;
          commit_pc_nxt_s    = ld_pc_r;
          if (ld_wen_r && (ld_rd_r != {ADDR_WIDTH{1'b0}})) begin
            rf_wen_nxt_s   = 1'b1;
            rf_waddr_nxt_s = ld_rd_r;
            rf_wdata_nxt_s = ld_data_s;
          end else begin
            rf_wen_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = WAIT_MEM;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and registered writeback/commit outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      rf_wen_r       <= 1'b0;
      rf_waddr_r     <= {ADDR_WIDTH{1'b0}};
      rf_wdata_r     <= {DATA_WIDTH{1'b0}};
      commit_valid_r <= 1'b0;
      commit_pc_r    <= 32'h0000_0000;
    end else begin
      state_r        <= state_nxt_s;
      rf_wen_r       <= rf_wen_nxt_s;
      rf_waddr_r     <= rf_waddr_nxt_s;
      rf_wdata_r     <= rf_wdata_nxt_s;
      commit_valid_r <= commit_valid_nxt_s;
      commit_pc_r    <= commit_pc_nxt_s;
    end
  end

  // Pending-load context captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rd_r      <= {ADDR_WIDTH{1'b0}};
      ld_wen_r     <= 1'b0;
      ld_funct3_r  <= 3'b000;
      ld_addr_lo_r <= 2'b00;
      ld_pc_r      <= 32'h0000_0000;
    end else if (capture_s) begin
      ld_rd_r      <= in_rd;
      ld_wen_r     <= in_wen;
      ld_funct3_r  <= in_funct3;
      ld_addr_lo_r <= in_addr_lo;
      ld_pc_r      <= in_pc;
    end else begin
      ld_rd_r      <= ld_rd_r;
    end
  end

endmodule

// File: tb/tb_npc_wbu.sv
// Directed self-checking bench for npc_wbu: ALU writes, back-to-back issue,
// load extension cases, x0 suppression and reset during a pending load.
module tb_npc_wbu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_pc;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc;

  int checks = 0;
  int errors = 0;

  npc_wbu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_wen       (in_wen),
    .in_result    (in_result),
    .in_is_load   (in_is_load),
    .in_funct3    (in_funct3),
    .in_addr_lo   (in_addr_lo),
    .in_pc        (in_pc),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .mem_rready   (mem_rready),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_alu(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                           input logic [31:0] pc);
    in_valid   = 1'b1;
    in_is_load = 1'b0;
    in_rd      = rd;
    in_wen     = wen;
    in_result  = res;
    in_pc      = pc;
  endtask

  // Accept a load, wait so mem_rvalid is sampled 3 cycles after accept, check result.
  task automatic run_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] pc,
                          input logic [31:0] data, input logic [31:0] exp);
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd      = rd;
    in_wen     = 1'b1;
    in_funct3  = f3;
    in_addr_lo = lo;
    in_pc      = pc;
    in_result  = 32'hCAFE_F00D;
    tick();
    in_valid = 1'b0;
    chk({tag, "_ready_lo"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_mrready"}, {31'd0, mem_rready}, 32'd1);
    chk({tag, "_nowen"}, {31'd0, rf_wen}, 32'd0);
    tick();
    tick();
    chk({tag, "_ready_wait"}, {31'd0, in_ready}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
    chk({tag, "_wen"}, {31'd0, rf_wen}, 32'd1);
    chk({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, rd});
    chk({tag, "_wdata"}, rf_wdata, exp);
    chk({tag, "_cpc"}, commit_pc, pc);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    tick();
    chk({tag, "_wen_drop"}, {31'd0, rf_wen}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_rd      = 5'd0;
    in_wen     = 1'b0;
    in_result  = 32'd0;
    in_is_load = 1'b0;
    in_funct3  = 3'b000;
    in_addr_lo = 2'b00;
    in_pc      = 32'd0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    tick();
    tick();
    chk("rst_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_cv", {31'd0, commit_valid}, 32'd0);
    chk("rst_cpc", commit_pc, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mrready", {31'd0, mem_rready}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single ALU write.
    issue_alu(5'd5, 1'b1, 32'hDEAD_BEEF, 32'h8000_0000);
    tick();
    in_valid = 1'b0;
    chk("alu_wen", {31'd0, rf_wen}, 32'd1);
    chk("alu_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("alu_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("alu_cv", {31'd0, commit_valid}, 32'd1);
    chk("alu_cpc", commit_pc, 32'h8000_0000);
    tick();
    chk("alu_wen_pulse", {31'd0, rf_wen}, 32'd0);
    chk("alu_cv_pulse", {31'd0, commit_valid}, 32'd0);
    chk("alu_waddr_hold", {27'd0, rf_waddr}, 32'd5);

    // Back-to-back ALU ops.
    for (int i = 1; i <= 3; i++) begin
      issue_alu(i[4:0], 1'b1, 32'h0000_0100 + i, 32'h0000_1000 + 4 * i);
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("b2b_wen", {31'd0, rf_wen}, 32'd1);
      chk("b2b_waddr", {27'd0, rf_waddr}, i);
      chk("b2b_wdata", rf_wdata, 32'h0000_0100 + i);
      chk("b2b_cpc", commit_pc, 32'h0000_1000 + 4 * i);
    end
    in_valid = 1'b0;
    tick();

    // Loads.
    run_load("lb",  5'd7,  3'b000, 2'd2, 32'h0000_2000, 32'h1280_5634, 32'hFFFF_FF80);
    run_load("lbu", 5'd8,  3'b100, 2'd2, 32'h0000_2004, 32'h1280_5634, 32'h0000_0080);
    run_load("lh",  5'd9,  3'b001, 2'd2, 32'h0000_2008, 32'h8000_1234, 32'hFFFF_8000);
    run_load("lhu", 5'd10, 3'b101, 2'd2, 32'h0000_200C, 32'h8000_1234, 32'h0000_8000);
    run_load("lw",  5'd11, 3'b010, 2'd0, 32'h0000_2010, 32'h8000_1234, 32'h8000_1234);
    run_load("lh3", 5'd12, 3'b001, 2'd3, 32'h0000_2014, 32'h8000_1234, 32'h0000_0080);
    run_load("lb1", 5'd13, 3'b000, 2'd1, 32'h0000_2018, 32'h1280_5634, 32'h0000_0056);

    // Write to x0 suppressed, commit still pulses, addr/data hold.
    issue_alu(5'd0, 1'b1, 32'h0000_0001, 32'h0000_3000);
    tick();
    in_valid = 1'b0;
    chk("x0_wen", {31'd0, rf_wen}, 32'd0);
    chk("x0_cv", {31'd0, commit_valid}, 32'd1);
    chk("x0_cpc", commit_pc, 32'h0000_3000);
    chk("x0_waddr", {27'd0, rf_waddr}, 32'd13);
    chk("x0_wdata", rf_wdata, 32'h0000_0056);

    // mem_rvalid in IDLE ignored.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("idle_rv_wen", {31'd0, rf_wen}, 32'd0);
    chk("idle_rv_cv", {31'd0, commit_valid}, 32'd0);
    chk("idle_rv_ready", {31'd0, in_ready}, 32'd1);

    // Reset during a pending load.
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd      = 5'd20;
    in_wen     = 1'b1;
    in_funct3  = 3'b010;
    in_addr_lo = 2'd0;
    in_pc      = 32'h0000_4000;
    tick();
    in_valid = 1'b0;
    chk("rstld_mrready", {31'd0, mem_rready}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rstld_ready", {31'd0, in_ready}, 32'd1);
    chk("rstld_mrready0", {31'd0, mem_rready}, 32'd0);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    chk("rstld_wen", {31'd0, rf_wen}, 32'd0);
    chk("rstld_cv", {31'd0, commit_valid}, 32'd0);
    chk("rstld_ready2", {31'd0, in_ready}, 32'd1);
    chk("rstld_waddr", {27'd0, rf_waddr}, 32'd0);
    tick();
    chk("rstld_cv2", {31'd0, commit_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
